// File: rtl/knn_sched_ctrl.sv
// Sequencer for the kNN distance datapath: loads Cold/Hot buffers through a row handshake and steps MLU pairs.
// Optional feature macro: KNN_SCHED_HOT_REUSE_EN (single HotBuffer fill per run when num_ref <= HOT_IMGS).
module knn_sched_ctrl #(
  parameter int ROWS_PER_IMG = 4,
  parameter int HOT_IMGS     = 16,
  parameter int COLD_IMGS    = 32,
  parameter int CNT_W        = 16,
  parameter int IDX_W        = 32,
  localparam int ROW_W = $clog2(ROWS_PER_IMG),
  localparam int HS_W  = $clog2(HOT_IMGS),
  localparam int CS_W  = $clog2(COLD_IMGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_test,
  input  logic [CNT_W-1:0]       num_ref,
  output logic                   busy,
  output logic                   done,
  output logic                   ld_req,
  output logic                   ld_buf,
  output logic [CNT_W-1:0]       ld_img,
  output logic [ROW_W-1:0]       ld_row,
  input  logic                   ld_ack,
  output logic [HS_W+ROW_W-1:0]  hot_idx,
  output logic                   hot_read_en,
  output logic                   hot_write_en,
  output logic [CS_W+ROW_W-1:0]  cold_idx,
  output logic                   cold_read_en,
  output logic                   cold_write_en,
  output logic [1:0]             symbol,
  output logic                   sel_in,
  output logic [2:0]             sel_output,
  output logic                   is_output,
  output logic                   clear_reg_acc,
  output logic                   clear_reg_sort,
  output logic                   asce,
  output logic [2:0]             fun_id,
  output logic [IDX_W-1:0]       index,
  output logic                   test_done,
  output logic [CNT_W-1:0]       test_id
);

  localparam int EW   = CNT_W + 1;
  localparam int PH_W = $clog2(ROWS_PER_IMG + 3);
  localparam logic [PH_W-1:0]  PH_DRAIN = PH_W'(ROWS_PER_IMG);
  localparam logic [PH_W-1:0]  PH_OUT   = PH_W'(ROWS_PER_IMG + 1);
  localparam logic [PH_W-1:0]  PH_CLR   = PH_W'(ROWS_PER_IMG + 2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS_PER_IMG - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_COLD, S_SORT_CLR, S_LD_HOT, S_PAIR, S_TDONE, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_test_q, num_test_d, num_ref_q, num_ref_d;
  logic [CNT_W-1:0]  tbase_q, tbase_d, rbase_q, rbase_d;
  logic [CS_W-1:0]   tslot_q, tslot_d, lslot_q, lslot_d;
  logic [HS_W-1:0]   rslot_q, rslot_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [PH_W-1:0]   ph_q, ph_d;
`ifdef KNN_SCHED_HOT_REUSE_EN
  logic              hot_valid_q, hot_valid_d;
`endif

  // Global image numbers carry one spare bit so "last image" compares cannot wrap.
  logic [EW-1:0] cold_img, hot_img, t_cur, r_cur;
  logic          cold_ld_last, hot_ld_last, t_last, r_last, rslot_end, tslot_end;

  assign cold_img     = EW'(tbase_q) + EW'(lslot_q);
  assign hot_img      = EW'(rbase_q) + EW'(lslot_q[HS_W-1:0]);
  assign t_cur        = EW'(tbase_q) + EW'(tslot_q);
  assign r_cur        = EW'(rbase_q) + EW'(rslot_q);
  assign cold_ld_last = (cold_img + EW'(1) >= EW'(num_test_q)) || (lslot_q == CS_W'(COLD_IMGS - 1));
  assign hot_ld_last  = (hot_img + EW'(1) >= EW'(num_ref_q)) || (lslot_q[HS_W-1:0] == HS_W'(HOT_IMGS - 1));
  assign t_last       = (t_cur + EW'(1) >= EW'(num_test_q));
  assign r_last       = (r_cur + EW'(1) >= EW'(num_ref_q));
  assign rslot_end    = r_last || (rslot_q == HS_W'(HOT_IMGS - 1));
  assign tslot_end    = (tslot_q == CS_W'(COLD_IMGS - 1));

  // NOTE: every output and next-state variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    num_test_d  = num_test_q;
    num_ref_d   = num_ref_q;
    tbase_d     = tbase_q;
    rbase_d     = rbase_q;
    tslot_d     = tslot_q;
    lslot_d     = lslot_q;
    rslot_d     = rslot_q;
    row_d       = row_q;
    ph_d        = ph_q;
`ifdef KNN_SCHED_HOT_REUSE_EN
    hot_valid_d = hot_valid_q;
`endif
    busy           = 1'b1;
    done           = 1'b0;
    ld_req         = 1'b0;
    ld_buf         = 1'b0;
    ld_img         = '0;
    ld_row         = '0;
    hot_idx        = '0;
    hot_read_en    = 1'b0;
    hot_write_en   = 1'b0;
    cold_idx       = '0;
    cold_read_en   = 1'b0;
    cold_write_en  = 1'b0;
    symbol         = 2'b00;
    sel_in         = 1'b0;
    sel_output     = 3'b000;
    is_output      = 1'b0;
    clear_reg_acc  = 1'b1;
    clear_reg_sort = 1'b0;
    asce           = 1'b0;
    fun_id         = 3'b000;
    index          = '0;
    test_done      = 1'b0;
    test_id        = '0;

    unique case (state_q)
      S_IDLE: begin
        busy           = 1'b0;
        clear_reg_sort = 1'b1;
        if (start) begin
          num_test_d  = num_test;
          num_ref_d   = num_ref;
          tbase_d     = '0;
          rbase_d     = '0;
          tslot_d     = '0;
          lslot_d     = '0;
          rslot_d     = '0;
          row_d       = '0;
          ph_d        = '0;
`ifdef KNN_SCHED_HOT_REUSE_EN
          hot_valid_d = 1'b0;
`endif
          state_d     = S_LD_COLD;
        end
      end

      S_LD_COLD: begin
        if (num_test_q == '0 || num_ref_q == '0) begin
          state_d = S_FIN;
        end else begin
          ld_req        = 1'b1;
          ld_buf        = 1'b1;
          ld_img        = cold_img[CNT_W-1:0];
          ld_row        = row_q;
          cold_idx      = {lslot_q, row_q};
          cold_write_en = ld_ack;
          if (ld_ack) begin
            row_d = row_q + ROW_W'(1);
            if (row_q == ROW_LAST) begin
              lslot_d = lslot_q + CS_W'(1);
              if (cold_ld_last) begin
                lslot_d = '0;
                tslot_d = '0;
                state_d = S_SORT_CLR;
              end
            end
          end
        end
      end

      S_SORT_CLR: begin
        clear_reg_sort = 1'b1;
        asce           = 1'b1;
        rbase_d        = '0;
        rslot_d        = '0;
        lslot_d        = '0;
        row_d          = '0;
        ph_d           = '0;
        state_d        = S_LD_HOT;
`ifdef KNN_SCHED_HOT_REUSE_EN
        if (hot_valid_q && num_ref_q <= CNT_W'(HOT_IMGS)) state_d = S_PAIR;
`endif
      end

      S_LD_HOT: begin
        ld_req       = 1'b1;
        ld_img       = hot_img[CNT_W-1:0];
        ld_row       = row_q;
        hot_idx      = {lslot_q[HS_W-1:0], row_q};
        hot_write_en = ld_ack;
        if (ld_ack) begin
          row_d = row_q + ROW_W'(1);
          if (row_q == ROW_LAST) begin
            lslot_d = lslot_q + CS_W'(1);
            if (hot_ld_last) begin
              lslot_d     = '0;
              rslot_d     = '0;
              ph_d        = '0;
`ifdef KNN_SCHED_HOT_REUSE_EN
              hot_valid_d = 1'b1;
`endif
              state_d     = S_PAIR;
            end
          end
        end
      end

      S_PAIR: begin
        // Phases: ROWS_PER_IMG reads, one drain for buffer read latency, output, accumulator clear.
        if (ph_q < PH_DRAIN) begin
          hot_read_en   = 1'b1;
          cold_read_en  = 1'b1;
          hot_idx       = {rslot_q, ph_q[ROW_W-1:0]};
          cold_idx      = {tslot_q, ph_q[ROW_W-1:0]};
          symbol        = 2'b10;
          clear_reg_acc = 1'b0;
        end else if (ph_q == PH_DRAIN) begin
          clear_reg_acc = 1'b0;
        end else if (ph_q == PH_OUT) begin
          sel_output    = 3'b110;
          is_output     = 1'b1;
          index         = IDX_W'(r_cur[CNT_W-1:0]);
          clear_reg_acc = 1'b0;
        end
        ph_d = ph_q + PH_W'(1);
        if (ph_q == PH_CLR) begin
          ph_d    = '0;
          rslot_d = rslot_q + HS_W'(1);
          if (rslot_end) begin
            rslot_d = '0;
            if (r_last) begin
              state_d = S_TDONE;
            end else begin
              rbase_d = rbase_q + CNT_W'(HOT_IMGS);
              lslot_d = '0;
              row_d   = '0;
              state_d = S_LD_HOT;
            end
          end
        end
      end

      S_TDONE: begin
        test_done = 1'b1;
        test_id   = t_cur[CNT_W-1:0];
        if (t_last) begin
          state_d = S_FIN;
        end else if (tslot_end) begin
          tbase_d = tbase_q + CNT_W'(COLD_IMGS);
          tslot_d = '0;
          lslot_d = '0;
          row_d   = '0;
          state_d = S_LD_COLD;
        end else begin
          tslot_d = tslot_q + CS_W'(1);
          state_d = S_SORT_CLR;
        end
      end

      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      num_test_q  <= '0;
      num_ref_q   <= '0;
      tbase_q     <= '0;
      rbase_q     <= '0;
      tslot_q     <= '0;
      lslot_q     <= '0;
      rslot_q     <= '0;
      row_q       <= '0;
      ph_q        <= '0;
`ifdef KNN_SCHED_HOT_REUSE_EN
      hot_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      num_test_q  <= num_test_d;
      num_ref_q   <= num_ref_d;
      tbase_q     <= tbase_d;
      rbase_q     <= rbase_d;
      tslot_q     <= tslot_d;
      lslot_q     <= lslot_d;
      rslot_q     <= rslot_d;
      row_q       <= row_d;
      ph_q        <= ph_d;
`ifdef KNN_SCHED_HOT_REUSE_EN
      hot_valid_q <= hot_valid_d;
`endif
    end
  end

endmodule

// File: tb/tb_knn_sched_ctrl.sv
// Scoreboard bench for knn_sched_ctrl: a loop-level model predicts load rows, buffer reads, outputs and test strobes.
module tb_knn_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, ld_ack;
  logic [15:0] num_test, num_ref;
  logic        busy, done, ld_req, ld_buf;
  logic [15:0] ld_img;
  logic [1:0]  ld_row;
  logic [5:0]  hot_idx;
  logic        hot_read_en, hot_write_en;
  logic [6:0]  cold_idx;
  logic        cold_read_en, cold_write_en;
  logic [1:0]  symbol;
  logic        sel_in;
  logic [2:0]  sel_output;
  logic        is_output, clear_reg_acc, clear_reg_sort, asce;
  logic [2:0]  fun_id;
  logic [31:0] index;
  logic        test_done;
  logic [15:0] test_id;

  knn_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_test(num_test), .num_ref(num_ref),
    .busy(busy), .done(done), .ld_req(ld_req), .ld_buf(ld_buf), .ld_img(ld_img), .ld_row(ld_row),
    .ld_ack(ld_ack), .hot_idx(hot_idx), .hot_read_en(hot_read_en), .hot_write_en(hot_write_en),
    .cold_idx(cold_idx), .cold_read_en(cold_read_en), .cold_write_en(cold_write_en),
    .symbol(symbol), .sel_in(sel_in), .sel_output(sel_output), .is_output(is_output),
    .clear_reg_acc(clear_reg_acc), .clear_reg_sort(clear_reg_sort), .asce(asce), .fun_id(fun_id),
    .index(index), .test_done(test_done), .test_id(test_id)
  );

  always #5 clk = ~clk;

`ifdef KNN_SCHED_HOT_REUSE_EN
  localparam int HOT6 = 64;
`else
  localparam int HOT6 = 192;
`endif

  typedef struct { bit is_cold; int img; int row; int idx; } ld_ev_t;
  typedef struct { int h; int c; } rd_ev_t;

  ld_ev_t ld_q[$];
  rd_ev_t rd_q[$];
  int     out_q[$];
  int     td_q[$];

  int total = 0, bad = 0;
  int ack_mode = 0;
  int done_cnt, sort_cnt, out_cnt, hot_wr_cnt, stall_cnt, ld_req_cnt, exp_sort, lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_sb();
    ld_q.delete(); rd_q.delete(); out_q.delete(); td_q.delete();
    done_cnt = 0; sort_cnt = 0; out_cnt = 0; hot_wr_cnt = 0; stall_cnt = 0; ld_req_cnt = 0; exp_sort = 0;
  endtask

  // Loop nest: test batch of 32 -> test image -> ref batch of 16 -> ref image; 4 rows per image.
  task automatic build_model(input int nt, input int nr);
    int tend, rend;
    bit load;
    if (nt == 0 || nr == 0) return;
    exp_sort = nt;
    for (int tb = 0; tb < nt; tb += 32) begin
      tend = (tb + 32 < nt) ? tb + 32 : nt;
      for (int t = tb; t < tend; t++)
        for (int r = 0; r < 4; r++) ld_q.push_back('{1'b1, t, r, (t - tb) * 4 + r});
      for (int t = tb; t < tend; t++) begin
        for (int rb = 0; rb < nr; rb += 16) begin
          rend = (rb + 16 < nr) ? rb + 16 : nr;
          load = 1'b1;
`ifdef KNN_SCHED_HOT_REUSE_EN
          if (nr <= 16 && t > 0) load = 1'b0;
`endif
          if (load)
            for (int f = rb; f < rend; f++)
              for (int r = 0; r < 4; r++) ld_q.push_back('{1'b0, f, r, (f - rb) * 4 + r});
          for (int f = rb; f < rend; f++) begin
            for (int r = 0; r < 4; r++) rd_q.push_back('{(f - rb) * 4 + r, (t - tb) * 4 + r});
            out_q.push_back(f);
          end
        end
        td_q.push_back(t);
      end
    end
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_ctl"}, {busy, done, ld_req, ld_buf, ld_row, hot_read_en, hot_write_en, cold_read_en,
                           cold_write_en, symbol, sel_in, sel_output, is_output, asce, fun_id, test_done}, 0);
    check({name, "_idx"}, {hot_idx, cold_idx}, 0);
    check({name, "_img"}, {ld_img, test_id}, 0);
    check({name, "_index"}, index, 0);
    check({name, "_clr"}, {clear_reg_acc, clear_reg_sort}, 2'b11);
  endtask

  // Loader model: ack policy 0=immediate, 1=random, 2=after three wait cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!ld_req) begin
        ld_ack = 1'b0; wcnt = 0;
      end else begin
        case (ack_mode)
          0: ld_ack = 1'b1;
          1: ld_ack = ($urandom_range(0, 2) == 0);
          default: if (wcnt == 3) begin ld_ack = 1'b1; wcnt = 0; end
                   else begin ld_ack = 1'b0; wcnt++; end
        endcase
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a load, read, output or strobe.
  initial begin
    ld_ev_t e;
    rd_ev_t r;
    int     v;
    bit     pend;
    logic [63:0] pend_v;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 1'b0;
      end else begin
        check("wr_en", {hot_write_en, cold_write_en},
              {ld_req & ld_ack & ~ld_buf, ld_req & ld_ack & ld_buf});
        if (pend) check("ld_hold", {ld_req, ld_buf, ld_img, ld_row}, pend_v);
        pend   = ld_req && !ld_ack;
        pend_v = {ld_req, ld_buf, ld_img, ld_row};
        if (ld_req) ld_req_cnt++;
        if (ld_req && !ld_ack) stall_cnt++;
        if (hot_write_en) hot_wr_cnt++;
        if (ld_req && ld_ack) begin
          if (ld_q.size() == 0) check("ld_extra", 1, 0);
          else begin
            e = ld_q.pop_front();
            check("ld_buf", ld_buf, e.is_cold);
            check("ld_img", ld_img, e.img);
            check("ld_row", ld_row, e.row);
            check("ld_idx", e.is_cold ? 64'(cold_idx) : 64'(hot_idx), e.idx);
            check("ld_rd_off", {hot_read_en, cold_read_en}, 0);
          end
        end
        if (hot_read_en || cold_read_en) begin
          if (rd_q.size() == 0) check("rd_extra", 1, 0);
          else begin
            r = rd_q.pop_front();
            check("rd_ctl", {hot_read_en, cold_read_en, symbol, sel_in, clear_reg_acc, ld_req}, 7'b11_10_0_0_0);
            check("rd_hot_idx", hot_idx, r.h);
            check("rd_cold_idx", cold_idx, r.c);
          end
        end
        if (is_output) begin
          out_cnt++;
          if (out_q.size() == 0) check("out_extra", 1, 0);
          else begin
            v = out_q.pop_front();
            check("out_index", index, v);
            check("out_ctl", {sel_output, clear_reg_acc}, 4'b110_0);
          end
        end
        if (test_done) begin
          if (td_q.size() == 0) check("tdone_extra", 1, 0);
          else begin
            v = td_q.pop_front();
            check("test_id", test_id, v);
          end
        end
        if (clear_reg_sort && busy) begin
          sort_cnt++;
          check("sort_asce", asce, 1);
        end
        if (done) begin
          done_cnt++;
          check("done_busy", busy, 0);
        end
      end
    end
  end

  task automatic run(input int nt, input int nr, input int mode, output int latency);
    bit got;
    ack_mode = mode;
    clear_sb();
    build_model(nt, nr);
    @(posedge clk); #1;
    num_test = 16'(nt); num_ref = 16'(nr); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; num_test = 16'($urandom); num_ref = 16'($urandom);
    latency = 0; got = 1'b0;
    while (!got && latency < 40000) begin
      @(negedge clk);
      latency++;
      if (latency == 21) start = 1'b0;
      if (done) got = 1'b1;
      else if (latency == 20 && busy) start = 1'b1;
    end
    check("done_seen", got, 1);
    if (!got) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("fin_start_ignored", busy, 0);
    check("ld_left", ld_q.size(), 0);
    check("rd_left", rd_q.size(), 0);
    check("out_left", out_q.size(), 0);
    check("tdone_left", td_q.size(), 0);
    check("done_count", done_cnt, 1);
    check("sort_count", sort_cnt, exp_sort);
    check("out_pulses", out_cnt, nt * nr);
  endtask

  initial begin
    bit found;
    rst = 1'b0; start = 1'b0; ld_ack = 1'b0; num_test = '0; num_ref = '0;
    clear_sb();
    #12;
    check_reset_outs("por");
    @(negedge clk); rst = 1'b1;

    run(1, 1, 0, lat);
    check("t1_hot_writes", hot_wr_cnt, 4);
    run(2, 17, 1, lat);
    run(1, 2, 2, lat);
    check("ack_wait_cycles", stall_cnt, 36);
    run(0, 5, 0, lat);
    check("zero_test_latency", lat, 2);
    check("zero_test_no_req", ld_req_cnt, 0);
    run(3, 0, 1, lat);
    check("zero_ref_latency", lat, 2);
    run(3, 16, 1, lat);
    check("hot_wr_total", hot_wr_cnt, HOT6);
    run(33, $urandom_range(1, 20), 1, lat);
    run($urandom_range(1, 10), $urandom_range(17, 20), 1, lat);
    run($urandom_range(1, 5), $urandom_range(1, 5), 1, lat);

    // Reset in the middle of a pair, then a clean run.
    ack_mode = 0;
    clear_sb();
    build_model(1, 2);
    @(posedge clk); #1;
    num_test = 16'd1; num_ref = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (hot_read_en && hot_idx[1:0] == 2'd2) found = 1'b1;
    end
    check("reach_r2", found, 1);
    #1 rst = 1'b0;
    #1 check_reset_outs("mid_rst");
    clear_sb();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    run(1, 1, 0, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
